// File: rtl/dqn_weight_bus_scheduler_pkg.sv
// dqn_weight_bus_scheduler_pkg: scheduler state encoding, layer codes and layer-size helpers
package dqn_weight_bus_scheduler_pkg;
  typedef enum logic [1:0] {S_INIT, S_IDLE, S_READ, S_WRITE} state_t;
  localparam int LAYER_1 = 1;
  localparam int LAYER_2 = 2;
  localparam int LAYER_3 = 3;
  function automatic int layer_size(input int layer, input int n_in, input int n_h1, input int n_h2, input int n_out);
    return layer == LAYER_1 ? n_h1 * (n_in + 1) : layer == LAYER_2 ? n_h2 * (n_h1 + 1) : n_out * (n_h2 + 1);
  endfunction
  localparam int DEFAULT_L1 = layer_size(LAYER_1, 2, 32, 32, 3);
  localparam int DEFAULT_L2 = layer_size(LAYER_2, 2, 32, 32, 3);
  localparam int DEFAULT_L3 = layer_size(LAYER_3, 2, 32, 32, 3);
endpackage

// File: rtl/dqn_weight_addr_counter.sv
// dqn_weight_addr_counter: layer/address sweep counter with stall, per-layer wrap and last flag
module dqn_weight_addr_counter
  import dqn_weight_bus_scheduler_pkg::*;
#(
  parameter int LAYER_WIDTH          = 2,
  parameter int WEIGHT_COUNTER_WIDTH = 11,
  parameter int L1                   = DEFAULT_L1,
  parameter int L2                   = DEFAULT_L2,
  parameter int L3                   = DEFAULT_L3
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            clear,
  input  logic                            advance,
  output logic [LAYER_WIDTH-1:0]          layer,
  output logic [WEIGHT_COUNTER_WIDTH-1:0] addr,
  output logic                            last
);
  logic [WEIGHT_COUNTER_WIDTH-1:0] top_addr;
  logic                            wrap;
  assign top_addr = layer == LAYER_WIDTH'(LAYER_1) ? WEIGHT_COUNTER_WIDTH'(L1 - 1) :
                    layer == LAYER_WIDTH'(LAYER_2) ? WEIGHT_COUNTER_WIDTH'(L2 - 1) :
                                                     WEIGHT_COUNTER_WIDTH'(L3 - 1);
  assign wrap = addr == top_addr;
  assign last = wrap && layer == LAYER_WIDTH'(LAYER_3);
  // step through each layer's weights, moving to the next layer on wrap and back to layer 1 after the last
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      layer <= LAYER_WIDTH'(LAYER_1);
      addr  <= '0;
    end else if (advance) begin
      addr  <= wrap ? '0 : addr + 1'b1;
      layer <= last ? LAYER_WIDTH'(LAYER_1) : wrap ? layer + 1'b1 : layer;
    end
  end
endmodule

// File: rtl/dqn_weight_bus_scheduler.sv
// dqn_weight_bus_scheduler: arbitrates the shared weight bus between init load, soft-update reads and write-backs
module dqn_weight_bus_scheduler
  import dqn_weight_bus_scheduler_pkg::*;
#(
  parameter int DATA_WIDTH                    = 32,
  parameter int LAYER_WIDTH                   = 2,
  parameter int WEIGHT_COUNTER_WIDTH          = 11,
  parameter int NUMBER_OF_INPUT_NODE          = 2,
  parameter int NUMBER_OF_HIDDEN_NODE_LAYER_1 = 32,
  parameter int NUMBER_OF_HIDDEN_NODE_LAYER_2 = 32,
  parameter int NUMBER_OF_OUTPUT_NODE         = 3
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            i_init_valid,
  input  logic [LAYER_WIDTH-1:0]          i_init_layer,
  input  logic [WEIGHT_COUNTER_WIDTH-1:0] i_init_addr,
  input  logic [DATA_WIDTH-1:0]           i_init_weight,
  input  logic                            i_update_request,
  input  logic                            i_train_busy,
  input  logic                            i_upd_valid,
  input  logic [LAYER_WIDTH-1:0]          i_upd_layer,
  input  logic [WEIGHT_COUNTER_WIDTH-1:0] i_upd_addr,
  input  logic [DATA_WIDTH-1:0]           i_upd_weight,
  input  logic                            i_upd_done,
  output logic                            o_weight_valid,
  output logic                            o_rw_weight_select,
  output logic [LAYER_WIDTH-1:0]          o_weight_layer,
  output logic [WEIGHT_COUNTER_WIDTH-1:0] o_weight_addr,
  output logic [DATA_WIDTH-1:0]           o_weight,
  output logic                            o_init_done,
  output logic                            o_update_busy,
  output logic                            o_update_done
);
  localparam int L1 = layer_size(LAYER_1, NUMBER_OF_INPUT_NODE, NUMBER_OF_HIDDEN_NODE_LAYER_1, NUMBER_OF_HIDDEN_NODE_LAYER_2, NUMBER_OF_OUTPUT_NODE);
  localparam int L2 = layer_size(LAYER_2, NUMBER_OF_INPUT_NODE, NUMBER_OF_HIDDEN_NODE_LAYER_1, NUMBER_OF_HIDDEN_NODE_LAYER_2, NUMBER_OF_OUTPUT_NODE);
  localparam int L3 = layer_size(LAYER_3, NUMBER_OF_INPUT_NODE, NUMBER_OF_HIDDEN_NODE_LAYER_1, NUMBER_OF_HIDDEN_NODE_LAYER_2, NUMBER_OF_OUTPUT_NODE);
  state_t                          state;
  logic                            pending;
  logic                            start;
  logic                            init_last;
  logic [LAYER_WIDTH-1:0]          cnt_layer;
  logic [WEIGHT_COUNTER_WIDTH-1:0] cnt_addr;
  logic                            cnt_last;
  assign start         = state == S_IDLE && pending && !i_train_busy;
  assign init_last     = i_init_layer == LAYER_WIDTH'(LAYER_3) && i_init_addr == WEIGHT_COUNTER_WIDTH'(L3 - 1);
  assign o_update_busy = state == S_READ || state == S_WRITE;
  dqn_weight_addr_counter #(
    .LAYER_WIDTH(LAYER_WIDTH), .WEIGHT_COUNTER_WIDTH(WEIGHT_COUNTER_WIDTH), .L1(L1), .L2(L2), .L3(L3)
  ) u_counter (
    .clk(clk), .rst(rst), .clear(start), .advance(state == S_READ && !i_upd_valid),
    .layer(cnt_layer), .addr(cnt_addr), .last(cnt_last)
  );
  // scheduler FSM: one bus transaction per cycle, write-backs pre-empt sweep reads
  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= S_INIT;
      pending            <= 1'b0;
      o_weight_valid     <= 1'b0;
      o_rw_weight_select <= 1'b0;
      o_weight_layer     <= '0;
      o_weight_addr      <= '0;
      o_weight           <= '0;
      o_init_done        <= 1'b0;
      o_update_done      <= 1'b0;
    end else begin
      pending        <= !start && (pending || i_update_request);
      o_weight_valid <= 1'b0;
      o_update_done  <= 1'b0;
      case (state)
        S_INIT: if (i_init_valid) begin
          o_weight_valid     <= 1'b1;
          o_rw_weight_select <= 1'b0;
          o_weight_layer     <= i_init_layer;
          o_weight_addr      <= i_init_addr;
          o_weight           <= i_init_weight;
          if (init_last) begin
            state       <= S_IDLE;
            o_init_done <= 1'b1;
          end
        end
        S_IDLE: if (start) state <= S_READ;
        S_READ: begin
          o_weight_valid     <= 1'b1;
          o_rw_weight_select <= !i_upd_valid;
          o_weight_layer     <= i_upd_valid ? i_upd_layer : cnt_layer;
          o_weight_addr      <= i_upd_valid ? i_upd_addr : cnt_addr;
          if (i_upd_valid) o_weight <= i_upd_weight;
          if (!i_upd_valid && cnt_last) state <= S_WRITE;
        end
        S_WRITE: begin
          if (i_upd_valid) begin
            o_weight_valid     <= 1'b1;
            o_rw_weight_select <= 1'b0;
            o_weight_layer     <= i_upd_layer;
            o_weight_addr      <= i_upd_addr;
            o_weight           <= i_upd_weight;
          end
          if (i_upd_done) begin
            state         <= S_IDLE;
            o_update_done <= 1'b1;
          end
        end
        default: state <= S_INIT;
      endcase
    end
  end
endmodule

// File: tb/tb_dqn_weight_bus_scheduler.sv
// tb_dqn_weight_bus_scheduler: table vectors, init/update sweeps against a flat-index reference, reset corner cases
module tb_dqn_weight_bus_scheduler;
  localparam int S1 = 32 * (2 + 1);
  localparam int S2 = 32 * (32 + 1);
  localparam int S3 = 3 * (32 + 1);
  localparam int TOTAL = S1 + S2 + S3;
  typedef struct {
    bit          v;
    logic [1:0]  layer;
    logic [10:0] addr;
    logic [31:0] w;
    bit          exp_valid;
    bit          exp_done;
  } vec_t;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_init_valid = 1'b0;
  logic [1:0]  i_init_layer = '0;
  logic [10:0] i_init_addr = '0;
  logic [31:0] i_init_weight = '0;
  logic        i_update_request = 1'b0;
  logic        i_train_busy = 1'b0;
  logic        i_upd_valid = 1'b0;
  logic [1:0]  i_upd_layer = '0;
  logic [10:0] i_upd_addr = '0;
  logic [31:0] i_upd_weight = '0;
  logic        i_upd_done = 1'b0;
  logic        o_weight_valid, o_rw_weight_select, o_init_done, o_update_busy, o_update_done;
  logic [1:0]  o_weight_layer;
  logic [10:0] o_weight_addr;
  logic [31:0] o_weight;
  int checks = 0;
  int errors = 0;
  vec_t tbl[5];
  always #5 clk = ~clk;
  dqn_weight_bus_scheduler dut (
    .clk(clk), .rst(rst),
    .i_init_valid(i_init_valid), .i_init_layer(i_init_layer), .i_init_addr(i_init_addr), .i_init_weight(i_init_weight),
    .i_update_request(i_update_request), .i_train_busy(i_train_busy),
    .i_upd_valid(i_upd_valid), .i_upd_layer(i_upd_layer), .i_upd_addr(i_upd_addr), .i_upd_weight(i_upd_weight),
    .i_upd_done(i_upd_done),
    .o_weight_valid(o_weight_valid), .o_rw_weight_select(o_rw_weight_select), .o_weight_layer(o_weight_layer),
    .o_weight_addr(o_weight_addr), .o_weight(o_weight), .o_init_done(o_init_done),
    .o_update_busy(o_update_busy), .o_update_done(o_update_done)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask
  function automatic void flat(input int k, output int l, output int a);
    if (k < S1) begin l = 1; a = k; end
    else if (k < S1 + S2) begin l = 2; a = k - S1; end
    else begin l = 3; a = k - S1 - S2; end
  endfunction
  task automatic pulse_request;
    i_update_request = 1'b1;
    tick;
    i_update_request = 1'b0;
  endtask
  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, o_weight_valid, 0);
    chk({tag, "_rw"}, o_rw_weight_select, 0);
    chk({tag, "_layer"}, o_weight_layer, 0);
    chk({tag, "_addr"}, o_weight_addr, 0);
    chk({tag, "_weight"}, o_weight, 0);
    chk({tag, "_init_done"}, o_init_done, 0);
    chk({tag, "_busy"}, o_update_busy, 0);
    chk({tag, "_upd_done"}, o_update_done, 0);
  endtask
  task automatic sweep(input int mode, input int stop_k, output int reads);
    int k = 0, cyc = 0, inj_cnt = 0, guard = 0, l, a;
    bit started = 0, inj;
    logic [31:0] w;
    while (k < stop_k && guard < 4000) begin
      guard++;
      inj = started && (mode == 0 ? (k == 10 && inj_cnt == 0) : ($urandom_range(0, 5) == 0));
      if (mode == 1 && started) i_train_busy = 1'($urandom_range(0, 1));
      i_upd_valid = inj;
      i_upd_layer = 2'($urandom_range(1, 3));
      i_upd_addr = 11'($urandom_range(0, 98));
      w = $urandom;
      i_upd_weight = w;
      tick;
      if (o_weight_valid) started = 1;
      if (started) begin
        chk("sweep_valid", o_weight_valid, 1);
        chk("sweep_busy", o_update_busy, 1);
      end
      if (o_weight_valid) begin
        cyc++;
        if (inj) begin
          chk("wb_rw", o_rw_weight_select, 0);
          chk("wb_layer", o_weight_layer, i_upd_layer);
          chk("wb_addr", o_weight_addr, i_upd_addr);
          chk("wb_weight", o_weight, w);
          inj_cnt++;
        end else begin
          flat(k, l, a);
          chk("rd_rw", o_rw_weight_select, 1);
          chk("rd_layer", o_weight_layer, 64'(l));
          chk("rd_addr", o_weight_addr, 64'(a));
          k++;
        end
      end
    end
    i_upd_valid = 1'b0;
    i_train_busy = 1'b0;
    chk("sweep_reads", k, stop_k);
    chk("sweep_cycles", cyc, k + inj_cnt);
    reads = k;
  endtask
  task automatic finish_update;
    i_upd_valid = 1'b1; i_upd_layer = 2'd2; i_upd_addr = 11'd7; i_upd_weight = 32'hCAFE_0001;
    tick;
    chk("fin_wr_valid", o_weight_valid, 1);
    chk("fin_wr_rw", o_rw_weight_select, 0);
    chk("fin_wr_addr", o_weight_addr, 7);
    chk("fin_wr_weight", o_weight, 32'hCAFE_0001);
    chk("fin_busy_before_done", o_update_busy, 1);
    chk("fin_done_early", o_update_done, 0);
    i_upd_layer = 2'd3; i_upd_addr = 11'd98; i_upd_weight = 32'hBEEF_0002; i_upd_done = 1'b1;
    tick;
    chk("fin_last_valid", o_weight_valid, 1);
    chk("fin_last_layer", o_weight_layer, 3);
    chk("fin_last_weight", o_weight, 32'hBEEF_0002);
    chk("fin_done_pulse", o_update_done, 1);
    chk("fin_busy_after", o_update_busy, 0);
    i_upd_valid = 1'b0; i_upd_done = 1'b0;
    tick;
    chk("fin_done_one_cycle", o_update_done, 0);
    chk("fin_idle_valid", o_weight_valid, 0);
  endtask
  initial begin
    int l, a, r, bad;
    logic [31:0] w;
    tbl[0] = '{1, 2'd1, 11'd0, 32'h1111_0000, 1, 0};
    tbl[1] = '{0, 2'd3, 11'd98, 32'h2222_0000, 0, 0};
    tbl[2] = '{1, 2'd2, 11'd1055, 32'h3333_0000, 1, 0};
    tbl[3] = '{1, 2'd3, 11'd97, 32'h4444_0000, 1, 0};
    tbl[4] = '{1, 2'd1, 11'd95, 32'h5555_0000, 1, 0};
    tick; tick;
    chk_all_zero("reset");
    rst = 1'b0;
    foreach (tbl[i]) begin
      i_init_valid = tbl[i].v; i_init_layer = tbl[i].layer; i_init_addr = tbl[i].addr; i_init_weight = tbl[i].w;
      tick;
      chk("tbl_valid", o_weight_valid, tbl[i].exp_valid);
      chk("tbl_done", o_init_done, tbl[i].exp_done);
      if (tbl[i].exp_valid) begin
        chk("tbl_rw", o_rw_weight_select, 0);
        chk("tbl_layer", o_weight_layer, tbl[i].layer);
        chk("tbl_addr", o_weight_addr, tbl[i].addr);
        chk("tbl_weight", o_weight, tbl[i].w);
      end
    end
    for (int k = 0; k < TOTAL; k++) begin
      flat(k, l, a);
      w = $urandom;
      i_init_valid = 1'b1; i_init_layer = 2'(l); i_init_addr = 11'(a); i_init_weight = w;
      tick;
      chk("init_valid", o_weight_valid, 1);
      chk("init_rw", o_rw_weight_select, 0);
      chk("init_layer", o_weight_layer, 64'(l));
      chk("init_addr", o_weight_addr, 64'(a));
      chk("init_weight", o_weight, w);
      chk("init_done", o_init_done, k == TOTAL - 1);
    end
    for (int i = 0; i < 5; i++) begin
      i_init_layer = 2'd1; i_init_addr = 11'(i);
      tick;
      chk("idle_init_ignored", o_weight_valid, 0);
      chk("idle_init_done_held", o_init_done, 1);
    end
    i_init_valid = 1'b0;
    pulse_request;
    sweep(0, TOTAL, r);
    finish_update;
    i_train_busy = 1'b1;
    pulse_request;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      i_update_request = (i == 5 || i == 10 || i == 15);
      tick;
      if (o_weight_valid || o_update_busy) bad++;
    end
    i_update_request = 1'b0;
    chk("train_busy_gate", bad, 0);
    i_train_busy = 1'b0;
    sweep(1, TOTAL, r);
    finish_update;
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      tick;
      if (o_weight_valid || o_update_busy) bad++;
    end
    chk("coalesced_single_sweep", bad, 0);
    pulse_request;
    sweep(0, S1 + 501, r);
    chk("rst_point_layer", o_weight_layer, 2);
    chk("rst_point_addr", o_weight_addr, 500);
    rst = 1'b1;
    tick;
    chk_all_zero("midrst");
    rst = 1'b0;
    i_init_valid = 1'b1; i_init_layer = 2'd1; i_init_addr = 11'd3; i_init_weight = 32'h0BAD_F00D;
    tick;
    i_init_valid = 1'b0;
    chk("reinit_valid", o_weight_valid, 1);
    chk("reinit_addr", o_weight_addr, 3);
    chk("reinit_weight", o_weight, 32'h0BAD_F00D);
    chk("reinit_done", o_init_done, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dqn_weight_bus_scheduler.md
DQN_WEIGHT_BUS_SCHEDULER -- requirements
Module: dqn_weight_bus_scheduler

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, weight word width.
REQ-002 SHALL have parameter LAYER_WIDTH, default 2, layer code width (1, 2 or 3).
REQ-003 SHALL have parameter WEIGHT_COUNTER_WIDTH, default 11, weight address width.
REQ-004 SHALL have parameters NUMBER_OF_INPUT_NODE=2, NUMBER_OF_HIDDEN_NODE_LAYER_1=32, NUMBER_OF_HIDDEN_NODE_LAYER_2=32, NUMBER_OF_OUTPUT_NODE=3.
REQ-005 SHALL have one clock and a synchronous, active-high reset: clk, input, 1, rising-edge clock; rst, input, 1, synchronous active-high reset.
REQ-006 Host init port: i_init_valid (in, 1); i_init_layer (in, LAYER_WIDTH); i_init_addr (in, WEIGHT_COUNTER_WIDTH); i_init_weight (in, DATA_WIDTH).
REQ-007 Control inputs: i_update_request (in, 1), soft-update trigger pulse; i_train_busy (in, 1), main-net training active.
REQ-008 Write-back port from soft-update unit: i_upd_valid (in, 1); i_upd_layer (in, LAYER_WIDTH); i_upd_addr (in, WEIGHT_COUNTER_WIDTH); i_upd_weight (in, DATA_WIDTH); i_upd_done (in, 1).
REQ-009 Shared weight bus to main and target nets: o_weight_valid (out, 1); o_rw_weight_select (out, 1; 1=read, 0=write); o_weight_layer (out, LAYER_WIDTH); o_weight_addr (out, WEIGHT_COUNTER_WIDTH); o_weight (out, DATA_WIDTH).
REQ-010 Status outputs: o_init_done (out, 1), level; o_update_busy (out, 1), level; o_update_done (out, 1), one-cycle pulse.

Function
REQ-011 Layer sizes SHALL be L1=H1*(IN+1)=96, L2=H2*(H1+1)=1056, L3=OUT*(H2+1)=99 at defaults.
REQ-012 FSM states SHALL be S_INIT, S_IDLE, S_READ, S_WRITE; reset state S_INIT.
REQ-013 S_INIT: each i_init_valid SHALL be forwarded as a write (rw=0) with the same layer/addr/weight, one-cycle registered latency.
REQ-014 S_INIT -> S_IDLE SHALL occur on an accepted init write with layer=3, addr=L3-1; o_init_done set next cycle and held until reset.
REQ-015 i_init_valid outside S_INIT SHALL be ignored (no bus activity).
REQ-016 i_update_request SHALL set a single pending flag in any state; repeated requests while pending or busy coalesce into one.
REQ-017 S_IDLE -> S_READ SHALL occur when pending=1 and i_train_busy=0; pending cleared, read counter set to layer 1, addr 0.
REQ-018 S_READ: each cycle SHALL issue one read (rw=1) at the counter, then advance addr; at size-1 wrap addr to 0 and increment layer.
REQ-019 S_READ: when i_upd_valid=1 the write-back SHALL be issued that cycle instead and the read counter SHALL stall.
REQ-020 After the read of layer 3, addr L3-1 is issued, FSM SHALL enter S_WRITE.
REQ-021 S_WRITE: each i_upd_valid SHALL be forwarded as a write; on i_upd_done FSM -> S_IDLE and o_update_done pulses one cycle.
REQ-022 i_upd_valid and i_upd_done in the same cycle: write SHALL be forwarded, then transition.
REQ-023 o_update_busy SHALL be 1 exactly in S_READ and S_WRITE.
REQ-024 Outside issued cycles o_weight_valid SHALL be 0; other bus fields hold last value.
REQ-025 i_train_busy SHALL only gate S_IDLE->S_READ; it does not abort an update in progress.

Reset
REQ-026 rst=1 at any clock edge SHALL force S_INIT, clear pending, counters to layer 1/addr 0, all outputs 0, including mid-update.

Structure
REQ-027 Shared package SHALL hold state encoding, layer codes 1..3 and layer-size constants derived from the node-count parameters.
REQ-028 One sub-module natural: dqn_weight_addr_counter (layer/addr counter with stall, per-layer wrap, last flag).

Verification
REQ-029 Init sweep 96+1056+99 writes, last (3,98) -> 1251 bus writes mirrored, o_init_done=1 one cycle after last.
REQ-030 Request in S_IDLE, train idle -> reads (1,0)..(1,95),(2,0)..(3,98), 1251 consecutive cycles, busy=1.
REQ-031 i_upd_valid at read cycle 10 -> write issued, read addr (1,10) issued next cycle, no address skipped.
REQ-032 Request with i_train_busy=1 for 20 cycles -> no read until busy falls; 3 extra requests meanwhile -> exactly one sweep.
REQ-033 Write-backs then i_upd_done in S_WRITE -> o_update_done pulse 1 cycle, busy=0, state S_IDLE.
REQ-034 rst at read (2,500) -> next cycle all outputs 0, o_init_done=0, init writes accepted again.
